// File: rtl/mem_wb_pkg.sv
// Types and helpers shared by the MEM/WB pipeline register and its load aligner.
`include "bus.v"

package mem_wb_pkg;

  typedef enum logic [2:0] {
    LT_LW  = `LOAD_LW,
    LT_LB  = `LOAD_LB,
    LT_LBU = `LOAD_LBU,
    LT_LH  = `LOAD_LH,
    LT_LHU = `LOAD_LHU
  } load_type_e;

  // Reserved codes 5-7 behave as LW, so they share the word-alignment rule.
  function automatic logic load_misaligned(input logic [2:0] load_type,
                                           input logic [1:0] addr_low);
    case (load_type)
      `LOAD_LB, `LOAD_LBU: return 1'b0;
      `LOAD_LH, `LOAD_LHU: return addr_low[0];
      default:             return (addr_low != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/bus.v
// Shared bus widths and load-type encodings used across the pipeline.
`ifndef BUS_V
`define BUS_V

`define DATA_BUS      31:0
`define REG_ADDR_BUS  4:0

`define LOAD_LW   3'd0
`define LOAD_LB   3'd1
`define LOAD_LBU  3'd2
`define LOAD_LH   3'd3
`define LOAD_LHU  3'd4

`endif

// File: rtl/mem_wb_load_align.sv
// Combinational byte/halfword lane select and sign/zero extension for loads.
`include "bus.v"

module load_align
  import mem_wb_pkg::*;
(
  input  logic [2:0]       load_type,
  input  logic [1:0]       addr_low,
  input  logic [`DATA_BUS] ram_data,
  output logic [`DATA_BUS] load_data,
  output logic             misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel   = ram_data[{addr_low, 3'b000} +: 8];
    half_sel   = addr_low[1] ? ram_data[31:16] : ram_data[15:0];
    misaligned = load_misaligned(load_type, addr_low);
    case (load_type)
      LT_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      LT_LBU:  load_data = {24'd0, byte_sel};
      LT_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      LT_LHU:  load_data = {16'd0, half_sel};
      default: load_data = ram_data;
    endcase
  end

endmodule

// File: rtl/mem_wb.sv
// MEM/WB pipeline register: formats load data, flags misaligned loads and
// counts retired instructions, presenting everything to the RegFile one cycle later.
`include "bus.v"

module mem_wb
  import mem_wb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 mem_valid,
  input  logic                 mem_write_en,
  input  logic [`REG_ADDR_BUS] mem_write_addr,
  input  logic [`DATA_BUS]     mem_result,
  input  logic                 mem_load_en,
  input  logic [2:0]           mem_load_type,
  input  logic [1:0]           mem_addr_low,
  input  logic [`DATA_BUS]     ram_read_data,
  output logic                 write_en,
  output logic [`REG_ADDR_BUS] write_addr,
  output logic [`DATA_BUS]     write_data,
  output logic                 misaligned_load,
  output logic [31:0]          retired_count
);

  logic [`DATA_BUS] load_data;
  logic             load_misalign;
  logic             misalign_now;

  load_align u_load_align (
    .load_type  (mem_load_type),
    .addr_low   (mem_addr_low),
    .ram_data   (ram_read_data),
    .load_data  (load_data),
    .misaligned (load_misalign)
  );

  assign misalign_now = mem_load_en && load_misalign;

  // Misaligned loads still retire; only their register write is suppressed.
  always_ff @(posedge clk) begin
    if (rst) begin
      write_en        <= 1'b0;
      write_addr      <= '0;
      write_data      <= '0;
      misaligned_load <= 1'b0;
      retired_count   <= 32'd0;
    end else if (flush || (!stall && !mem_valid)) begin
      write_en        <= 1'b0;
      write_addr      <= '0;
      write_data      <= '0;
      misaligned_load <= 1'b0;
    end else if (!stall) begin
      write_en        <= mem_write_en && !misalign_now;
      write_addr      <= mem_write_addr;
      write_data      <= mem_load_en ? load_data : mem_result;
      misaligned_load <= misalign_now;
      retired_count   <= retired_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_mem_wb.sv
// Directed self-checking bench for the MEM/WB pipeline register.
`include "bus.v"

module tb_mem_wb;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        mem_valid, mem_write_en, mem_load_en;
  logic [4:0]  mem_write_addr;
  logic [31:0] mem_result, ram_read_data;
  logic [2:0]  mem_load_type;
  logic [1:0]  mem_addr_low;
  logic        write_en, misaligned_load;
  logic [4:0]  write_addr;
  logic [31:0] write_data, retired_count;

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  mem_wb dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .flush           (flush),
    .mem_valid       (mem_valid),
    .mem_write_en    (mem_write_en),
    .mem_write_addr  (mem_write_addr),
    .mem_result      (mem_result),
    .mem_load_en     (mem_load_en),
    .mem_load_type   (mem_load_type),
    .mem_addr_low    (mem_addr_low),
    .ram_read_data   (ram_read_data),
    .write_en        (write_en),
    .write_addr      (write_addr),
    .write_data      (write_data),
    .misaligned_load (misaligned_load),
    .retired_count   (retired_count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Drives one cycle of MEM-stage inputs, then samples 1ns after the edge.
  task automatic applyStimulus(input logic r, input logic s, input logic f,
                               input logic v, input logic we, input logic [4:0] wa,
                               input logic [31:0] res, input logic le,
                               input logic [2:0] lt, input logic [1:0] al,
                               input logic [31:0] ram);
    rst = r; stall = s; flush = f;
    mem_valid = v; mem_write_en = we; mem_write_addr = wa;
    mem_result = res; mem_load_en = le; mem_load_type = lt;
    mem_addr_low = al; ram_read_data = ram;
    @(posedge clk);
    #1;
  endtask

  task automatic checkAll(input string tag, input logic we, input logic [4:0] wa,
                          input logic [31:0] wd, input logic mis, input logic [31:0] cnt);
    checkOutput({tag, ".we"},    {31'd0, write_en},        {31'd0, we});
    checkOutput({tag, ".addr"},  {27'd0, write_addr},      {27'd0, wa});
    checkOutput({tag, ".data"},  write_data,               wd);
    checkOutput({tag, ".mis"},   {31'd0, misaligned_load}, {31'd0, mis});
    checkOutput({tag, ".count"}, retired_count,            cnt);
  endtask

  initial begin
    // reset, overriding concurrent stall/flush and a valid instruction
    applyStimulus(1, 1, 1, 1, 1, 5'd9, 32'hAAAA_5555, 0, `LOAD_LW, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, `LOAD_LW, 0, 0);
    checkAll("reset", 0, 0, 0, 0, 0);

    applyStimulus(0, 0, 0, 1, 1, 5'd5, 32'h0000_1234, 0, `LOAD_LW, 0, 0);
    checkAll("alu_r5", 1, 5'd5, 32'h0000_1234, 0, 1);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 1, 1, 5'd7, 32'hDEAD_BEEF, 0, `LOAD_LW, 0, 0);
      checkAll($sformatf("stall%0d", i), 1, 5'd5, 32'h0000_1234, 0, 1);
    end

    applyStimulus(0, 0, 0, 1, 1, 5'd3, 0, 1, `LOAD_LB, 2'd3, 32'h80FF_1234);
    checkAll("lb_a3", 1, 5'd3, 32'hFFFF_FF80, 0, 2);

    applyStimulus(0, 0, 0, 1, 1, 5'd4, 0, 1, `LOAD_LBU, 2'd1, 32'h80FF_1234);
    checkAll("lbu_a1", 1, 5'd4, 32'h0000_0012, 0, 3);

    applyStimulus(0, 0, 0, 1, 1, 5'd6, 0, 1, `LOAD_LH, 2'd0, 32'h1234_8001);
    checkAll("lh_a0", 1, 5'd6, 32'hFFFF_8001, 0, 4);

    applyStimulus(0, 0, 0, 1, 1, 5'd8, 0, 1, `LOAD_LHU, 2'd2, 32'h8001_7FFF);
    checkAll("lhu_a2", 1, 5'd8, 32'h0000_8001, 0, 5);

    applyStimulus(0, 0, 0, 1, 1, 5'd10, 32'h1111_1111, 1, `LOAD_LW, 2'd0, 32'hCAFE_BABE);
    checkAll("lw_a0", 1, 5'd10, 32'hCAFE_BABE, 0, 6);

    applyStimulus(0, 0, 0, 1, 1, 5'd11, 0, 1, `LOAD_LW, 2'd1, 32'hCAFE_BABE);
    checkOutput("lw_a1.we", {31'd0, write_en}, 32'd0);
    checkOutput("lw_a1.mis", {31'd0, misaligned_load}, 32'd1);
    checkOutput("lw_a1.count", retired_count, 32'd7);

    applyStimulus(0, 0, 0, 0, 1, 5'd12, 32'h9999_9999, 0, `LOAD_LW, 0, 0);
    checkAll("bubble", 0, 0, 0, 0, 7);

    applyStimulus(0, 0, 0, 1, 1, 5'd13, 0, 1, `LOAD_LH, 2'd1, 32'h1234_5678);
    checkOutput("lh_a1.we", {31'd0, write_en}, 32'd0);
    checkOutput("lh_a1.mis", {31'd0, misaligned_load}, 32'd1);
    checkOutput("lh_a1.count", retired_count, 32'd8);

    applyStimulus(0, 0, 0, 1, 1, 5'd14, 0, 1, 3'd5, 2'd0, 32'h0BAD_F00D);
    checkAll("rsv5_a0", 1, 5'd14, 32'h0BAD_F00D, 0, 9);

    applyStimulus(0, 0, 0, 1, 1, 5'd15, 0, 1, 3'd6, 2'd2, 32'h0BAD_F00D);
    checkOutput("rsv6_a2.we", {31'd0, write_en}, 32'd0);
    checkOutput("rsv6_a2.mis", {31'd0, misaligned_load}, 32'd1);

    applyStimulus(0, 0, 0, 1, 1, 5'd0, 32'h0000_0055, 0, `LOAD_LW, 0, 0);
    checkAll("r0_pass", 1, 5'd0, 32'h0000_0055, 0, 11);

    applyStimulus(0, 1, 1, 1, 1, 5'd20, 32'h7777_7777, 0, `LOAD_LW, 0, 0);
    checkAll("flush_stall", 0, 0, 0, 0, 11);

    applyStimulus(0, 0, 0, 1, 0, 5'd21, 32'h0000_ABCD, 0, `LOAD_LW, 0, 0);
    checkAll("store", 0, 5'd21, 32'h0000_ABCD, 0, 12);

    // preload the counter to its maximum while stalled, then retire one more
    stall = 1'b1;
    force dut.retired_count = 32'hFFFF_FFFF;
    #1;
    release dut.retired_count;
    applyStimulus(0, 1, 0, 1, 1, 5'd1, 32'h1, 0, `LOAD_LW, 0, 0);
    checkOutput("preload.count", retired_count, 32'hFFFF_FFFF);
    applyStimulus(0, 0, 0, 1, 1, 5'd2, 32'h0000_0042, 0, `LOAD_LW, 0, 0);
    checkAll("wrap", 1, 5'd2, 32'h0000_0042, 0, 0);

    applyStimulus(0, 0, 0, 1, 1, 5'd11, 0, 1, `LOAD_LW, 2'd3, 32'h1234_5678);
    applyStimulus(0, 1, 0, 1, 1, 5'd9, 32'h5, 0, `LOAD_LW, 0, 0);
    checkOutput("mis_stall.mis", {31'd0, misaligned_load}, 32'd1);
    checkOutput("mis_stall.count", retired_count, 32'd1);
    applyStimulus(1, 1, 1, 1, 1, 5'd9, 32'h5, 0, `LOAD_LW, 0, 0);
    checkAll("rst_mid_stall", 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/mem_wb.md
MEM_WB -- requirements
Module: mem_wb

Interface
REQ-001 The module SHALL have the port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-002 The module SHALL have the port rst, input, 1 bit, a synchronous active-high reset sampled on the rising edge of clk.
REQ-003 The module SHALL have the port stall, input, 1 bit; when high, all registered state holds.
REQ-004 The module SHALL have the port flush, input, 1 bit; when high, it inserts a bubble.
REQ-005 The module SHALL have the port mem_valid, input, 1 bit; it qualifies the MEM-stage instruction.
REQ-006 The module SHALL have the port mem_write_en, input, 1 bit; it is the register write request from the MEM stage.
REQ-007 The module SHALL have the port mem_write_addr, input, `REG_ADDR_BUS (5 bits), the destination register.
REQ-008 The module SHALL have the port mem_result, input, `DATA_BUS (32 bits), the ALU result for non-load instructions.
REQ-009 The module SHALL have the port mem_load_en, input, 1 bit; it marks the instruction as a load.
REQ-010 The module SHALL have the port mem_load_type, input, 3 bits, encoded as 0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU; codes 5-7 are reserved and treated as LW.
REQ-011 The module SHALL have the port mem_addr_low, input, 2 bits, the byte offset of the load address.
REQ-012 The module SHALL have the port ram_read_data, input, `DATA_BUS, the little-endian word read from RAM, valid in the MEM cycle.
REQ-013 The module SHALL have the port write_en, output, 1 bit, driven to the RegFile write channel.
REQ-014 The module SHALL have the port write_addr, output, `REG_ADDR_BUS, driven to the RegFile.
REQ-015 The module SHALL have the port write_data, output, `DATA_BUS, driven to the RegFile.
REQ-016 The module SHALL have the port misaligned_load, output, 1 bit, the registered exception flag.
REQ-017 The module SHALL have the port retired_count, output, 32 bits, the count of instructions retired.

Function
REQ-018 All outputs SHALL be registered, with exactly one cycle of latency from MEM-stage inputs to outputs.
REQ-019 Update priority per edge SHALL be: rst, then flush, then stall, then normal capture.
REQ-020 On flush, write_en and misaligned_load SHALL be 0, write_addr and write_data SHALL be 0, and retired_count SHALL be unchanged.
REQ-021 On stall without flush, all registers including retired_count SHALL hold their values.
REQ-022 On normal capture with mem_valid=0, the block SHALL capture a bubble with the same values as a flush.
REQ-023 On normal capture with mem_valid=1 and mem_load_en=0, the block SHALL capture write_data=mem_result, write_en=mem_write_en and write_addr=mem_write_addr.
REQ-024 For LB/LBU, the selected byte SHALL be ram_read_data[8*a+7:8*a] with a=mem_addr_low; LB sign-extends it and LBU zero-extends it.
REQ-025 For LH/LHU, the selected halfword SHALL be lane mem_addr_low[1]; LH sign-extends it and LHU zero-extends it.
REQ-026 For LW, the block SHALL capture ram_read_data unmodified.
REQ-027 A load SHALL be misaligned when it is LH/LHU with mem_addr_low[0]=1, or LW/reserved with mem_addr_low≠0.
REQ-028 A misaligned load SHALL capture write_en=0 and misaligned_load=1; misaligned_load lasts one cycle unless stalled.
REQ-029 mem_write_addr=0 SHALL pass through unchanged; suppressing writes to r0 is the RegFile's job.
REQ-030 retired_count SHALL increment by 1 on each normal capture with mem_valid=1, including misaligned loads, and SHALL wrap from 0xFFFFFFFF to 0.

Reset
REQ-031 On rst, write_en, write_addr, write_data, misaligned_load and retired_count SHALL all be 0 at the next edge.
REQ-032 rst SHALL override a concurrent stall and flush.
REQ-033 An instruction in flight when rst is asserted SHALL be discarded.

Structure
REQ-034 `DATA_BUS, `REG_ADDR_BUS and the load-type encodings SHALL be defined in the shared bus.v include, not locally.
REQ-035 Load alignment and extension SHALL be one combinational sub-module named load_align, instantiated once.

Verification
REQ-036 The bench SHALL drive LB at a=3 with ram=0x80FF_1234 and require write_data=0xFFFF_FF80 and write_en=1 one cycle later.
REQ-037 The bench SHALL drive LHU at a=2 with ram=0x8001_7FFF and require write_data=0x0000_8001.
REQ-038 The bench SHALL drive LW at a=1 and require write_en=0, misaligned_load=1 for one cycle, and retired_count +1.
REQ-039 The bench SHALL apply stall for 3 cycles after an ALU result 0x1234 to r5, and require the outputs held at r5/0x1234 and retired_count frozen.
REQ-040 The bench SHALL assert flush and stall in the same cycle and require a bubble (write_en=0) with retired_count unchanged.
REQ-041 The bench SHALL preload retired_count to 0xFFFF_FFFF via 2^32-1 retires or a force, retire one more instruction, and require 0; it SHALL then assert rst mid-stall and require all outputs 0.
